// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_fsm
// Description : Multicycle main controller for the 16-bit CPU. Sequences
//               FETCH / DECODE / EXEC / MEM / WB, selects ALU operands and
//               the ALU-control mode, and owns every datapath write strobe.
//
// Parameters  : CNT_W        width of the retired-instruction counter
//
// Ports       : Clock        system clock, rising edge
//               ResetN       asynchronous active-low reset
//               Opcode[3:0]  IR[15:12], sampled into OpReg during DECODE
//               Zero         ALU zero flag (meaningful in EXEC)
//               MemReady     memory completes current access this cycle
//               ALUOp[1:0]   00 add, 01 sub, 10 R-format, 11 I-format
//               ALUSrcA      0 = PC, 1 = rs
//               ALUSrcB[1:0] 00 rt, 01 const 2, 10 sext imm, 11 sext imm<<1
//               PCSrc[1:0]   00 ALU result, 01 branch target, 10 jump target
//               PCWrite, IRWrite, MemRead, MemWrite, RegWrite  strobes
//               RegDst       1 = rd, 0 = rt
//               MemToReg     1 = memory data, 0 = ALU result
//               State[2:0]   current state (debug)
//               Illegal      sticky illegal-opcode flag
//               InstRetired  retired-instruction count (wraps)
//
// Build option: FSM_ILLEGAL_TRAP_EN
//               defined   : an illegal opcode parks the FSM in TRAP with the
//                           sticky Illegal flag set; only reset leaves TRAP.
//               undefined : an illegal opcode is a NOP that returns to FETCH
//                           without retiring; Illegal is tied low.
//
// Revision    : 1.0  initial release
// ============================================================================
module multicycle_control_fsm #(
    parameter int CNT_W = 16
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic [3:0]       Opcode,
    input  logic             Zero,
    input  logic             MemReady,
    output logic [1:0]       ALUOp,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSrc,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             MemToReg,
    output logic [2:0]       State,
    output logic             Illegal,
    output logic [CNT_W-1:0] InstRetired
);

    // ------------------------------------------------------------------
    // State encoding (values are visible on the State debug port)
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Opcode map
    // ------------------------------------------------------------------
    localparam logic [3:0] c_OP_R0   = 4'b0000;
    localparam logic [3:0] c_OP_R1   = 4'b0001;
    localparam logic [3:0] c_OP_R2   = 4'b0010;
    localparam logic [3:0] c_OP_BEQ  = 4'b0100;
    localparam logic [3:0] c_OP_BNE  = 4'b0101;
    localparam logic [3:0] c_OP_J    = 4'b1000;
    localparam logic [3:0] c_OP_ADDI = 4'b1001;
    localparam logic [3:0] c_OP_SUBI = 4'b1010;
    localparam logic [3:0] c_OP_SLTI = 4'b1011;
    localparam logic [3:0] c_OP_LW   = 4'b1100;
    localparam logic [3:0] c_OP_SW   = 4'b1101;

    function automatic logic f_is_legal(input logic [3:0] op);
        logic legal;
        case (op)
            c_OP_R0, c_OP_R1, c_OP_R2,
            c_OP_BEQ, c_OP_BNE, c_OP_J,
            c_OP_ADDI, c_OP_SUBI, c_OP_SLTI,
            c_OP_LW, c_OP_SW:  legal = 1'b1;
            default:           legal = 1'b0;
        endcase
        return legal;
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [3:0]       r_opreg;
    logic [CNT_W-1:0] r_inst_retired;

    // ------------------------------------------------------------------
    // Combinational next state / control
    // ------------------------------------------------------------------
    state_t     w_next_state;
    logic       w_retire;
    logic [1:0] w_alu_op;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_pc_src;
    logic       w_pc_write;
    logic       w_ir_write;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_reg_write;
    logic       w_reg_dst;
    logic       w_mem_to_reg;

    always_comb begin
        w_next_state = r_state;
        w_alu_op     = 2'b00;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = 2'b00;
        w_pc_src     = 2'b00;
        w_pc_write   = 1'b0;
        w_ir_write   = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;

        case (r_state)
            ST_FETCH: begin
                // PC + 2 is computed every fetch cycle; it is only
                // committed once memory returns the instruction.
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                if (MemReady) begin
                    w_ir_write   = 1'b1;
                    w_pc_write   = 1'b1;
                    w_next_state = ST_DECODE;
                end
            end

            ST_DECODE: begin
                // Speculatively form the branch target PC + (imm << 1).
                w_alu_src_b = 2'b11;
                if (f_is_legal(Opcode)) begin
                    w_next_state = ST_EXEC;
                end else begin
`ifdef FSM_ILLEGAL_TRAP_EN
                    w_next_state = ST_TRAP;
`else
                    w_next_state = ST_FETCH;
`endif
                end
            end

            ST_EXEC: begin
                case (r_opreg)
                    c_OP_R0, c_OP_R1, c_OP_R2: begin
                        w_alu_src_a  = 1'b1;
                        w_alu_op     = 2'b10;
                        w_next_state = ST_WB;
                    end
                    c_OP_ADDI, c_OP_SUBI, c_OP_SLTI: begin
                        w_alu_src_a  = 1'b1;
                        w_alu_src_b  = 2'b10;
                        w_alu_op     = 2'b11;
                        w_next_state = ST_WB;
                    end
                    c_OP_LW, c_OP_SW: begin
                        w_alu_src_a  = 1'b1;
                        w_alu_src_b  = 2'b10;
                        w_next_state = ST_MEM;
                    end
                    c_OP_BEQ, c_OP_BNE: begin
                        // Compare rs - rt; the PC strobe follows Zero in the
                        // same cycle so the branch target reg is used directly.
                        w_alu_src_a  = 1'b1;
                        w_alu_op     = 2'b01;
                        w_pc_src     = 2'b01;
                        w_pc_write   = (r_opreg == c_OP_BEQ) ? Zero : ~Zero;
                        w_next_state = ST_FETCH;
                    end
                    c_OP_J: begin
                        w_pc_src     = 2'b10;
                        w_pc_write   = 1'b1;
                        w_next_state = ST_FETCH;
                    end
                    default: begin
                        w_next_state = ST_FETCH;
                    end
                endcase
            end

            ST_MEM: begin
                if (r_opreg == c_OP_LW) begin
                    w_mem_read = 1'b1;
                end else begin
                    w_mem_write = 1'b1;
                end
                if (MemReady) begin
                    w_next_state = (r_opreg == c_OP_LW) ? ST_WB : ST_FETCH;
                end
            end

            ST_WB: begin
                w_reg_write  = 1'b1;
                w_reg_dst    = (r_opreg == c_OP_R0) || (r_opreg == c_OP_R1) ||
                               (r_opreg == c_OP_R2);
                w_mem_to_reg = (r_opreg == c_OP_LW);
                w_next_state = ST_FETCH;
            end

            ST_TRAP: begin
`ifdef FSM_ILLEGAL_TRAP_EN
                w_next_state = ST_TRAP;
`else
                w_next_state = ST_FETCH;
`endif
            end

            default: begin
                w_next_state = ST_FETCH;
            end
        endcase
    end

    // An instruction retires when control returns to FETCH from any of the
    // execution states; the illegal-opcode NOP path leaves from DECODE.
    always_comb begin
        w_retire = 1'b0;
        if (w_next_state == ST_FETCH) begin
            w_retire = (r_state == ST_EXEC) || (r_state == ST_MEM) ||
                       (r_state == ST_WB);
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_state        <= ST_FETCH;
            r_opreg        <= 4'b0000;
            r_inst_retired <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_DECODE) begin
                r_opreg <= Opcode;
            end
            if (w_retire) begin
                r_inst_retired <= r_inst_retired + CNT_W'(1);
            end
        end
    end

`ifdef FSM_ILLEGAL_TRAP_EN
    logic r_illegal;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_illegal <= 1'b0;
        end else if (w_next_state == ST_TRAP) begin
            r_illegal <= 1'b1;
        end
    end

    assign Illegal = r_illegal;
`else
    assign Illegal = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs. FETCH is the reset state and would otherwise drive MemRead
    // while ResetN is low, so every control output is gated by ResetN.
    // ------------------------------------------------------------------
    assign ALUOp       = ResetN ? w_alu_op     : 2'b00;
    assign ALUSrcA     = ResetN & w_alu_src_a;
    assign ALUSrcB     = ResetN ? w_alu_src_b  : 2'b00;
    assign PCSrc       = ResetN ? w_pc_src     : 2'b00;
    assign PCWrite     = ResetN & w_pc_write;
    assign IRWrite     = ResetN & w_ir_write;
    assign MemRead     = ResetN & w_mem_read;
    assign MemWrite    = ResetN & w_mem_write;
    assign RegWrite    = ResetN & w_reg_write;
    assign RegDst      = ResetN & w_reg_dst;
    assign MemToReg    = ResetN & w_mem_to_reg;
    assign State       = r_state;
    assign InstRetired = r_inst_retired;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control_fsm
// Description : Self-checking bench for multicycle_control_fsm. Each
//               instruction is expanded from its opcode class into the
//               expected cycle-by-cycle trace (state, control fields,
//               retired count, Illegal) and compared against the DUT.
// Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_control_fsm;

    localparam int CW = 4;   // narrow counter so wrap-around is reached

    // control bus layout: {ALUOp, ALUSrcA, ALUSrcB, PCSrc, PCWrite, IRWrite,
    //                      MemRead, MemWrite, RegWrite, RegDst, MemToReg}
    localparam logic [13:0] M_ALU = 14'h3E00;
    localparam logic [13:0] M_PC  = 14'h0180;
    localparam logic [13:0] M_STB = 14'h007C;
    localparam logic [13:0] M_RD  = 14'h0003;
    localparam logic [13:0] M_ALL = 14'h3FFF;

    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4,
                   K_BNE = 5, K_J = 6, K_ILL = 7;

    logic          Clock = 1'b0;
    logic          ResetN = 1'b0;
    logic [3:0]    Opcode = 4'b0;
    logic          Zero = 1'b0;
    logic          MemReady = 1'b0;
    logic [1:0]    ALUOp;
    logic          ALUSrcA;
    logic [1:0]    ALUSrcB;
    logic [1:0]    PCSrc;
    logic          PCWrite, IRWrite, MemRead, MemWrite, RegWrite;
    logic          RegDst, MemToReg;
    logic [2:0]    State;
    logic          Illegal;
    logic [CW-1:0] InstRetired;

    multicycle_control_fsm #(.CNT_W(CW)) dut (
        .Clock      (Clock),
        .ResetN     (ResetN),
        .Opcode     (Opcode),
        .Zero       (Zero),
        .MemReady   (MemReady),
        .ALUOp      (ALUOp),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .PCSrc      (PCSrc),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .RegDst     (RegDst),
        .MemToReg   (MemToReg),
        .State      (State),
        .Illegal    (Illegal),
        .InstRetired(InstRetired)
    );

    always #5 Clock = ~Clock;

    logic [13:0] ctl_bus;
    assign ctl_bus = {ALUOp, ALUSrcA, ALUSrcB, PCSrc, PCWrite, IRWrite,
                      MemRead, MemWrite, RegWrite, RegDst, MemToReg};

    int            n_vec = 0;
    int            n_err = 0;
    logic [CW-1:0] exp_ret = '0;
    logic          exp_ill = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [13:0] mk(input logic [1:0] aop, input logic sa,
                                       input logic [1:0] sb, input logic [1:0] ps,
                                       input logic pw, input logic iw,
                                       input logic mr, input logic mw,
                                       input logic rw, input logic rd,
                                       input logic mt);
        return {aop, sa, sb, ps, pw, iw, mr, mw, rw, rd, mt};
    endfunction

    function automatic int op_class(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010: return K_R;
            4'b1001, 4'b1010, 4'b1011: return K_I;
            4'b1100:                   return K_LW;
            4'b1101:                   return K_SW;
            4'b0100:                   return K_BEQ;
            4'b0101:                   return K_BNE;
            4'b1000:                   return K_J;
            default:                   return K_ILL;
        endcase
    endfunction

    // One clock cycle: drive inputs on the falling edge, check just after.
    task automatic cyc(input logic [2:0] st, input logic [13:0] val,
                       input logic [13:0] msk, input logic mr,
                       input logic [3:0] op, input logic z);
        @(negedge Clock);
        MemReady = mr;
        Opcode   = op;
        Zero     = z;
        #1;
        check("state", State, st);
        check("ctl", ctl_bus & msk, val & msk);
        check("retired", InstRetired, exp_ret);
        check("illegal", Illegal, exp_ill);
    endtask

    task automatic apply_reset();
        ResetN   = 1'b0;
        MemReady = 1'b0;
        exp_ret  = '0;
        exp_ill  = 1'b0;
        #1;
        check("rst_state", State, 3'd0);
        check("rst_ctl", ctl_bus & M_ALL, 14'h0);
        check("rst_retired", InstRetired, exp_ret);
        check("rst_illegal", Illegal, exp_ill);
        @(negedge Clock);
        Opcode = 4'($urandom);
        Zero   = 1'($urandom);
        #1;
        check("rst_hold_state", State, 3'd0);
        check("rst_hold_ctl", ctl_bus & M_ALL, 14'h0);
        ResetN = 1'b1;
    endtask

    // Expected trace of one complete instruction.
    task automatic do_instr(input logic [3:0] op, input int fst, input int mst,
                            input logic zv);
        int k;
        k = op_class(op);
        for (int i = 0; i < fst; i++)
            cyc(3'd0, mk(2'b00, 1'b0, 2'b01, 2'b00, 0, 0, 1, 0, 0, 0, 0),
                M_ALU | M_STB, 1'b0, 4'($urandom), 1'($urandom));
        cyc(3'd0, mk(2'b00, 1'b0, 2'b01, 2'b00, 1, 1, 1, 0, 0, 0, 0),
            M_ALU | M_PC | M_STB, 1'b1, 4'($urandom), 1'($urandom));
        cyc(3'd1, mk(2'b00, 1'b0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0),
            M_ALU | M_STB, 1'($urandom), op, 1'($urandom));

        if (k == K_ILL) begin
`ifdef FSM_ILLEGAL_TRAP_EN
            exp_ill = 1'b1;
            for (int i = 0; i < 20; i++)
                cyc(3'd5, 14'h0, M_STB, 1'($urandom), 4'($urandom), 1'($urandom));
            apply_reset();
`endif
            return;
        end

        case (k)
            K_R:   cyc(3'd2, mk(2'b10, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0),
                       M_ALU | M_STB, 1'($urandom), 4'($urandom), 1'($urandom));
            K_I:   cyc(3'd2, mk(2'b11, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0),
                       M_ALU | M_STB, 1'($urandom), 4'($urandom), 1'($urandom));
            K_LW, K_SW:
                   cyc(3'd2, mk(2'b00, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0),
                       M_ALU | M_STB, 1'($urandom), 4'($urandom), 1'($urandom));
            K_BEQ: cyc(3'd2, mk(2'b01, 1, 2'b00, 2'b01, zv, 0, 0, 0, 0, 0, 0),
                       M_ALU | M_PC | M_STB, 1'($urandom), 4'($urandom), zv);
            K_BNE: cyc(3'd2, mk(2'b01, 1, 2'b00, 2'b01, !zv, 0, 0, 0, 0, 0, 0),
                       M_ALU | M_PC | M_STB, 1'($urandom), 4'($urandom), zv);
            default: // jump
                   cyc(3'd2, mk(2'b00, 0, 2'b00, 2'b10, 1, 0, 0, 0, 0, 0, 0),
                       M_PC | M_STB, 1'($urandom), 4'($urandom), 1'($urandom));
        endcase

        if (k == K_LW || k == K_SW) begin
            for (int i = 0; i <= mst; i++)
                cyc(3'd3, mk(2'b00, 0, 2'b00, 2'b00, 0, 0, k == K_LW, k == K_SW, 0, 0, 0),
                    M_STB, (i == mst), 4'($urandom), 1'($urandom));
        end

        if (k == K_R || k == K_I || k == K_LW)
            cyc(3'd4, mk(2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, k == K_R, k == K_LW),
                M_STB | M_RD, 1'($urandom), 4'($urandom), 1'($urandom));

        exp_ret = exp_ret + 1'b1;
    endtask

    initial begin
        #3;
        apply_reset();

        // register-format add, no stalls
        do_instr(4'b0001, 0, 0, 1'b0);

        // reset arriving in the middle of EXEC of an ADD
        cyc(3'd0, mk(2'b00, 1'b0, 2'b01, 2'b00, 1, 1, 1, 0, 0, 0, 0),
            M_ALU | M_PC | M_STB, 1'b1, 4'b0000, 1'b0);
        cyc(3'd1, 14'h0, M_STB, 1'b1, 4'b0000, 1'b0);
        cyc(3'd2, mk(2'b10, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0),
            M_ALU | M_STB, 1'b1, 4'b0000, 1'b0);
        apply_reset();

        // directed opcode cases
        do_instr(4'b1100, 0, 3, 1'b0);   // LW with 3 memory stall cycles
        do_instr(4'b0100, 0, 0, 1'b1);   // BEQ taken
        do_instr(4'b0101, 0, 0, 1'b1);   // BNE not taken
        do_instr(4'b0100, 1, 0, 1'b0);   // BEQ not taken
        do_instr(4'b0101, 0, 0, 1'b0);   // BNE taken
        do_instr(4'b1011, 0, 0, 1'b0);   // SLTI
        do_instr(4'b1101, 2, 1, 1'b0);   // SW
        do_instr(4'b1000, 0, 0, 1'b0);   // J
        do_instr(4'b1111, 0, 0, 1'b0);   // illegal
        do_instr(4'b0010, 0, 0, 1'b0);   // follows the illegal opcode

        // randomized instruction stream (counter wraps several times)
        for (int n = 0; n < 300; n++) begin
            logic [3:0] op;
            int fs, ms;
            op = 4'($urandom);
            fs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            ms = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
            do_instr(op, fs, ms, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
